fifo_sc_ew_req_drain: RTL

Read-side master for the team's request-based single-clock FIFOs, which use a rd_val request and return data exactly one cycle later with rd_val/rd_dat.
- Watches FIFO empty status and issues read requests.
- Captures the returned words in a small local buffer.
- Presents the words downstream on a valid/ready interface.
- Sits between any fifo_sc_ew_req_* instance and a backpressuring consumer; guarantees no read-empty request and no lost return data.

---
 rtl/fifo_sc_ew_req_drain_pkg.sv | 12 +
 rtl/buf_vr_reg_based.sv | 47 ++++
 rtl/fifo_sc_ew_req_drain.sv | 80 ++++++++
 3 files changed

// File: rtl/fifo_sc_ew_req_drain_pkg.sv
// Shared helpers for the request-based FIFO drain block.
// FUNC_LOG2 is the ceiling log2 used to size pointers and counts, with a minimum of 1.
package fifo_sc_ew_req_drain_pkg;

  function automatic int FUNC_LOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/buf_vr_reg_based.sv
// Small register-based skid FIFO with push/pop and an occupancy count.
// Pointers wrap explicitly, so SIZE does not have to be a power of 2.
module buf_vr_reg_based
  import fifo_sc_ew_req_drain_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int SIZE    = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push,
  input  logic [DATA_WD-1:0]             push_dat,
  input  logic                           pop,
  output logic                           val,
  output logic [DATA_WD-1:0]             dat,
  output logic [FUNC_LOG2(SIZE+1)-1:0]   cnt
);

  localparam int PW = FUNC_LOG2(SIZE);
  localparam int CW = FUNC_LOG2(SIZE+1);
  localparam logic [PW-1:0] LAST = PW'(SIZE-1);

  logic [SIZE-1:0][DATA_WD-1:0] mem;
  logic [PW-1:0]                wp;
  logic [PW-1:0]                rp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_dat;
        wp      <= (wp == LAST) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= (rp == LAST) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Head entry is registered, so data stays stable until it is popped.
  assign val = (cnt != '0);
  assign dat = mem[rp];

endmodule

// File: rtl/fifo_sc_ew_req_drain.sv
// Read-side master for request-based single-clock FIFOs: issues credit-limited
// reads, captures the 1-cycle-latency returns and drains them on valid/ready.
module fifo_sc_ew_req_drain
  import fifo_sc_ew_req_drain_pkg::*;
#(
  parameter int DATA_WD  = 32,
  parameter int BUF_SIZE = 3,
  parameter int CNT_WD   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en_i,
  input  logic               fifo_rd_ept_i,
  output logic               fifo_rd_val_o,
  input  logic               fifo_rd_val_i,
  input  logic [DATA_WD-1:0] fifo_rd_dat_i,
  output logic               out_val_o,
  output logic [DATA_WD-1:0] out_dat_o,
  input  logic               out_rdy_i,
  output logic               busy_o,
  output logic [CNT_WD-1:0]  cnt_o
);

  localparam int CW = FUNC_LOG2(BUF_SIZE+1);

  generate
    if (BUF_SIZE < 2 || BUF_SIZE > 8) begin : g_bad_size
      $error("fifo_sc_ew_req_drain: BUF_SIZE must be within 2..8");
    end
  endgenerate

  logic [CW-1:0] buf_cnt;
  logic [CW:0]   credit_used;
  logic          inflight_r;
  logic          pop;

  // Credit ignores a same-cycle pop so ready never reaches the FIFO request.
  assign credit_used   = {1'b0, buf_cnt} + {{CW{1'b0}}, inflight_r};
  assign fifo_rd_val_o = en_i && !fifo_rd_ept_i && (credit_used < (CW+1)'(BUF_SIZE));
  assign pop           = out_val_o && out_rdy_i;
  assign busy_o        = inflight_r || (buf_cnt != '0);

  buf_vr_reg_based #(
    .DATA_WD (DATA_WD),
    .SIZE    (BUF_SIZE)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifo_rd_val_i),
    .push_dat (fifo_rd_dat_i),
    .pop      (pop),
    .val      (out_val_o),
    .dat      (out_dat_o),
    .cnt      (buf_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_r <= 1'b0;
      cnt_o      <= '0;
    end else begin
      inflight_r <= fifo_rd_val_o;
      if (pop) cnt_o <= cnt_o + 1'b1;
    end
  end

`ifdef SIM_KNOB_DBG
  always_ff @(posedge clk) begin
    if (rstn && fifo_rd_val_i && !inflight_r) begin
      $error("fifo_sc_ew_req_drain: return data without an outstanding request");
      $finish;
    end
    if (rstn && fifo_rd_val_i && !pop && (buf_cnt == CW'(BUF_SIZE))) begin
      $error("fifo_sc_ew_req_drain: push into full skid buffer");
      $finish;
    end
  end
`endif

endmodule
